// File: rtl/multi_channel_pixel_sampler.sv
// Recovers CHANNELS oversampled TTL video bits by majority vote over each pixel window.
// A phase accumulator sets fractional window lengths, and a resync rising edge re-phases it.

module multi_channel_pixel_sampler_lane #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic             sample,
  input  logic [CNT_W-1:0] win_len_incl,
  output logic             vote
);
  logic [CNT_W-1:0] ones_q, ones_d, ones_incl;

  assign ones_incl = ones_q + CNT_W'(sample);
  // Strict majority: an even-window tie votes 0.
  assign vote = {ones_incl, 1'b0} > {1'b0, win_len_incl};

  always_comb begin
    ones_d = ones_q;
    if (clr)       ones_d = '0;
    else if (step) ones_d = ones_incl;
  end

  always_ff @(posedge clk) begin
    if (reset) ones_q <= '0;
    else       ones_q <= ones_d;
  end
endmodule

module multi_channel_pixel_sampler #(
  parameter int CHANNELS   = 4,
  parameter int NUM        = 44,
  parameter int DEN        = 5,
  parameter int PHASE_INIT = 0,
  parameter int X_W        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] data_in,
  input  logic                resync,
  output logic [CHANNELS-1:0] data_out,
  output logic                data_valid,
  output logic [X_W-1:0]      pix_x
);
  localparam int ACC_W   = $clog2(NUM + DEN) + 1;
  localparam int WIN_MAX = (NUM + DEN - 1) / DEN;
  localparam int CNT_W   = $clog2(WIN_MAX + 1);
  localparam logic [ACC_W-1:0] NUM_A   = ACC_W'(NUM);
  localparam logic [ACC_W-1:0] DEN_A   = ACC_W'(DEN);
  localparam logic [ACC_W-1:0] PHASE_A = ACC_W'(PHASE_INIT);

  logic [CHANNELS-1:0] data_s1_q, data_s2_q;
  logic                rs_s1_q, rs_s2_q, rs_s3_q;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]    win_len_q, win_len_d, win_len_incl;
  logic [X_W-1:0]      x_cnt_q, x_cnt_d, pix_x_q, pix_x_d;
  logic [CHANNELS-1:0] data_out_q, data_out_d, vote;
  logic                data_valid_q, data_valid_d;
  logic                rise, step, boundary;

  // Synchronisers keep running while enable is low so a resync edge is never missed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1_q <= '0;
      data_s2_q <= '0;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rs_s3_q   <= 1'b0;
    end else begin
      data_s1_q <= data_in;
      data_s2_q <= data_s1_q;
      rs_s1_q   <= resync;
      rs_s2_q   <= rs_s1_q;
      rs_s3_q   <= rs_s2_q;
    end
  end

  assign rise         = rs_s2_q & ~rs_s3_q;
  assign step         = enable & ~rise;
  assign acc_sum      = acc_q + DEN_A;
  assign boundary     = step & (acc_sum >= NUM_A);
  assign win_len_incl = win_len_q + CNT_W'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    multi_channel_pixel_sampler_lane #(.CNT_W(CNT_W)) u_lane (
      .clk          (clk),
      .reset        (reset),
      .clr          (rise | boundary),
      .step         (step),
      .sample       (data_s2_q[c]),
      .win_len_incl (win_len_incl),
      .vote         (vote[c])
    );
  end

  always_comb begin
    acc_d        = acc_q;
    win_len_d    = win_len_q;
    x_cnt_d      = x_cnt_q;
    data_out_d   = data_out_q;
    pix_x_d      = pix_x_q;
    data_valid_d = 1'b0;
    if (rise) begin
      // Partial window is dropped; this cycle's sample is discarded.
      acc_d     = PHASE_A;
      win_len_d = '0;
      x_cnt_d   = '0;
    end else if (enable) begin
      if (boundary) begin
        acc_d        = acc_sum - NUM_A;
        win_len_d    = '0;
        data_out_d   = vote;
        data_valid_d = 1'b1;
        pix_x_d      = x_cnt_q;
        x_cnt_d      = (&x_cnt_q) ? x_cnt_q : x_cnt_q + X_W'(1);
      end else begin
        acc_d     = acc_sum;
        win_len_d = win_len_incl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= PHASE_A;
      win_len_q    <= '0;
      x_cnt_q      <= '0;
      data_out_q   <= '0;
      pix_x_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      win_len_q    <= win_len_d;
      x_cnt_q      <= x_cnt_d;
      data_out_q   <= data_out_d;
      pix_x_q      <= pix_x_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pix_x      = pix_x_q;
endmodule

// File: tb/tb_multi_channel_pixel_sampler.sv
// Directed bench: three sampler instances (44/5, 9/1, 44/5 with 3-bit pix_x),
// each with its own stimulus, against hand-computed strobe positions and votes.

module tb_multi_channel_pixel_sampler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din [3];
  logic       en [3];
  logic       rs [3];
  logic [3:0] dout [3];
  logic       dv [3];
  logic [9:0] px_a, px_b;
  logic [2:0] px_c;

  int n_chk = 0;
  int n_err = 0;
  int pos_q[$];
  int px_q[$];
  logic [3:0] do_q[$];
  int exp_pos[$];
  int exp_px[$];

  always #5 clk = ~clk;

  multi_channel_pixel_sampler #(.CHANNELS(4), .NUM(44), .DEN(5), .PHASE_INIT(0), .X_W(10)) u_a (
    .clk(clk), .reset(reset), .enable(en[0]), .data_in(din[0]), .resync(rs[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .pix_x(px_a));
  multi_channel_pixel_sampler #(.CHANNELS(4), .NUM(9), .DEN(1), .PHASE_INIT(0), .X_W(10)) u_b (
    .clk(clk), .reset(reset), .enable(en[1]), .data_in(din[1]), .resync(rs[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .pix_x(px_b));
  multi_channel_pixel_sampler #(.CHANNELS(4), .NUM(44), .DEN(5), .PHASE_INIT(0), .X_W(3)) u_c (
    .clk(clk), .reset(reset), .enable(en[2]), .data_in(din[2]), .resync(rs[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .pix_x(px_c));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int get_px(input int sel);
    case (sel)
      0:       return int'(px_a);
      1:       return int'(px_b);
      default: return int'(px_c);
    endcase
  endfunction

  // One isolated sample: settle the synchroniser with enable low, then enable for one edge.
  task automatic feed(input int sel, input logic [3:0] v);
    en[sel]  = 1'b0;
    din[sel] = v;
    repeat (3) tick();
    en[sel] = 1'b1;
    tick();
    en[sel] = 1'b0;
  endtask

  task automatic feed_win(input string tag, input int sel, input int n, input logic [3:0] a,
                          input int na, input logic [3:0] b, input logic [3:0] exp_do,
                          input int exp_x);
    for (int k = 1; k <= n; k++) begin
      feed(sel, (k <= na) ? a : b);
      chk($sformatf("%s_dv%0d", tag, k), int'(dv[sel]), int'(k == n));
    end
    chk({tag, "_do"}, int'(dout[sel]), int'(exp_do));
    chk({tag, "_px"}, get_px(sel), exp_x);
  endtask

  // Free-running capture; iteration i ends at the negedge after sample edge i.
  task automatic run_rec(input int sel, input int n, input int rs_lo_at, input int rs_hi_at);
    pos_q.delete(); px_q.delete(); do_q.delete();
    for (int i = 1; i <= n; i++) begin
      if (i == rs_lo_at) rs[sel] = 1'b0;
      if (i == rs_hi_at) rs[sel] = 1'b1;
      tick();
      if (dv[sel]) begin
        pos_q.push_back(i);
        px_q.push_back(get_px(sel));
        do_q.push_back(dout[sel]);
      end
    end
  endtask

  task automatic check_rec(input string tag, input logic [3:0] exp_do);
    chk({tag, "_nstrobe"}, pos_q.size(), exp_pos.size());
    for (int k = 0; k < exp_pos.size() && k < pos_q.size(); k++) begin
      chk($sformatf("%s_pos%0d", tag, k), pos_q[k], exp_pos[k]);
      chk($sformatf("%s_px%0d", tag, k), px_q[k], exp_px[k]);
      chk($sformatf("%s_do%0d", tag, k), int'(do_q[k]), int'(exp_do));
    end
  endtask

  initial begin
    int pause_strobes;
    for (int s = 0; s < 3; s++) begin
      din[s] = 4'b0000; en[s] = 1'b0; rs[s] = 1'b0;
    end

    // Reset with toggling data, then one cycle after release
    for (int k = 0; k < 3; k++) begin
      din[0] = (k % 2 == 0) ? 4'b1111 : 4'b0101;
      tick();
      chk($sformatf("rst%0d_dv", k), int'(dv[0]), 0);
      chk($sformatf("rst%0d_do", k), int'(dout[0]), 0);
      chk($sformatf("rst%0d_px", k), int'(px_a), 0);
    end
    reset = 1'b0;
    tick();
    chk("rel_dv", int'(dv[0]), 0);
    chk("rel_do", int'(dout[0]), 0);
    chk("rel_px", int'(px_a), 0);

    // Constant 1010, 44/5: windows 9,9,9,9,8
    din[0] = 4'b1010;
    repeat (3) tick();
    en[0] = 1'b1;
    run_rec(0, 88, -1, -1);
    en[0] = 1'b0;
    exp_pos = '{9, 18, 27, 36, 44, 53, 62, 71, 80, 88};
    exp_px  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_rec("cont", 4'b1010);

    // Majority on 9-sample windows (9/1)
    feed_win("maj5", 1, 9, 4'b1101, 5, 4'b0100, 4'b1101, 0);
    feed_win("maj4", 1, 9, 4'b1000, 5, 4'b0011, 4'b1000, 1);

    // 44/5 from acc=0: four 9-windows then an 8-window with a 4/8 tie on ch0
    feed_win("w9a", 0, 9, 4'b1111, 9, 4'b0000, 4'b1111, 10);
    feed_win("w9b", 0, 9, 4'b0000, 9, 4'b0000, 4'b0000, 11);
    feed_win("w9c", 0, 9, 4'b1001, 9, 4'b0000, 4'b1001, 12);
    feed_win("w9d", 0, 9, 4'b0110, 9, 4'b0000, 4'b0110, 13);
    feed_win("tie8", 0, 8, 4'b0111, 4, 4'b0110, 4'b0110, 14);

    // Resync rise at window sample 4: partial dropped, restart from pix_x=0
    din[0] = 4'b1111;
    repeat (3) tick();
    en[0] = 1'b1;
    run_rec(0, 22, -1, 2);
    en[0] = 1'b0;
    exp_pos = '{13, 22};
    exp_px  = '{0, 1};
    check_rec("resync", 4'b1111);

    // Enable pause mid-window (acc=2, 9-window): 5 ones, pause, 4 zeros -> votes 1
    en[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("pre_dv%0d", k), int'(dv[0]), 0);
    end
    en[0] = 1'b0;
    din[0] = 4'b0000;
    pause_strobes = 0;
    repeat (20) begin
      tick();
      if (dv[0]) pause_strobes++;
    end
    chk("pause_strobes", pause_strobes, 0);
    en[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("post_dv%0d", k), int'(dv[0]), int'(k == 4));
    end
    en[0] = 1'b0;
    chk("pause_do", int'(dout[0]), 4'b1111);
    chk("pause_px", int'(px_a), 2);
    repeat (5) tick();
    chk("hold_do", int'(dout[0]), 4'b1111);
    chk("hold_dv", int'(dv[0]), 0);

    // X_W=3 saturation, then a rise coincident with a boundary (sample 97)
    din[2] = 4'b1010;
    rs[2]  = 1'b1;
    repeat (3) tick();
    en[2] = 1'b1;
    run_rec(2, 106, 51, 95);
    en[2] = 1'b0;
    exp_pos = '{9, 18, 27, 36, 44, 53, 62, 71, 80, 88, 106};
    exp_px  = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0};
    check_rec("sat", 4'b1010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
